// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-channel result FIFOs drained one entry per cycle
// onto a registered broadcast bus using round-robin priority.
module cdb_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 6,
    parameter int BUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH*TAG_W-1:0]    req_tag,
    input  logic [NUM_CH*DATA_W-1:0]   req_data,
    input  logic [NUM_CH-1:0]          req_branch,
    input  logic [NUM_CH-1:0]          req_branch_taken,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic                       cdb_branch,
    output logic                       cdb_branch_taken,
    output logic [$clog2(NUM_CH)-1:0]  cdb_ch
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int ENT_W = TAG_W + DATA_W + 2;

    logic [ENT_W-1:0] r_mem  [NUM_CH][BUF_DEPTH];
    logic [PTR_W-1:0] r_wptr [NUM_CH];
    logic [PTR_W-1:0] r_rptr [NUM_CH];
    logic [CNT_W-1:0] r_cnt  [NUM_CH];
    logic [CH_W-1:0]  r_rr;

    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_nonempty;
    logic              w_gnt_found;
    logic [CH_W-1:0]   w_gnt_idx;
    logic [CH_W-1:0]   w_rr_nxt;
    logic [ENT_W-1:0]  w_head;

    // Ready looks only at the registered count, so a full FIFO refuses a write
    // even when it is popped in the same cycle.
    always_comb begin
        req_ready  = '0;
        w_push     = '0;
        w_nonempty = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req_ready[i]  = (r_cnt[i] != CNT_W'(BUF_DEPTH));
            w_push[i]     = req_valid[i] & req_ready[i] & ~flush;
            w_nonempty[i] = (r_cnt[i] != '0);
        end
    end

    // Walk from the farthest candidate back to r_rr so the closest one wins.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_nonempty[CH_W'((int'(r_rr) + k) % NUM_CH)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = CH_W'((int'(r_rr) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pop[i] = w_gnt_found & (w_gnt_idx == CH_W'(i)) & ~flush;
        end
        w_rr_nxt = (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
        w_head   = r_mem[w_gnt_idx][r_rptr[w_gnt_idx]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_rr <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_rr <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
                if (w_push[i] && !w_pop[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_pop[i] && !w_push[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
            if (w_gnt_found) r_rr <= w_rr_nxt;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wptr[i]] <= {req_tag[i*TAG_W +: TAG_W], req_data[i*DATA_W +: DATA_W],
                                        req_branch[i], req_branch_taken[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid        <= 1'b0;
            cdb_tag          <= '0;
            cdb_data         <= '0;
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
            cdb_ch           <= '0;
        end else if (flush || !w_gnt_found) begin
            cdb_valid        <= 1'b0;
            cdb_tag          <= '0;
            cdb_data         <= '0;
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
            cdb_ch           <= '0;
        end else begin
            cdb_valid        <= 1'b1;
            cdb_tag          <= w_head[ENT_W-1 -: TAG_W];
            cdb_data         <= w_head[DATA_W+1 -: DATA_W];
            cdb_branch       <= w_head[1];
            cdb_branch_taken <= w_head[0];
            cdb_ch           <= w_gnt_idx;
        end
    end

endmodule
